// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the RV32F issue controller: op classes, result-source
// encodings, iterative-unit FSM states and the write-back horizon (LMAX).
package fp_ctrl_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_MUL    = 3'b001;
  localparam logic [2:0] OP_DIV    = 3'b010;
  localparam logic [2:0] OP_SQRT   = 3'b011;
  localparam logic [2:0] OP_SIMPLE = 3'b100;

  localparam logic [1:0] SEL_PIPE   = 2'b00;
  localparam logic [1:0] SEL_SIMPLE = 2'b01;
  localparam logic [1:0] SEL_ITER   = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } iter_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] sel;
  } rsv_entry_t;

  // Longest issue-to-writeback latency; sqrt only counts when the unit exists.
  function automatic int calc_lmax(input int div_cycles, input int sqrt_cycles,
                                   input int pipe_lat, input bit sqrt_en);
    int m;
    m = 1;
    if (pipe_lat > m) m = pipe_lat;
    if (div_cycles > m) m = div_cycles;
    if (sqrt_en && (sqrt_cycles > m)) m = sqrt_cycles;
    return m;
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Per-f-register pending bits with set/clear and a 4-port hazard lookup.
// A bit retiring this cycle is already invisible to the lookup.
module fp_scoreboard
  import fp_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rs3,
  input  logic [4:0] rd,
  input  logic       use_rs3,
  input  logic       use_rd,
  output logic       hazard
);

  logic [31:0] pending_reg;
  logic [31:0] pending_next;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] visible;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_mask
      assign set_mask[gi] = set_en && (set_idx == 5'(gi));
      assign clr_mask[gi] = clr_en && (clr_idx == 5'(gi));
    end
  endgenerate

  // Set is applied after clear so a same-index collision stays pending.
  assign pending_next = (pending_reg & ~clr_mask) | set_mask;
  assign visible      = pending_reg & ~clr_mask;

  assign hazard = visible[rs1] | visible[rs2] | (use_rs3 & visible[rs3]) |
                  (use_rd & visible[rd]);

  always_ff @(posedge clk) begin
    if (reset) pending_reg <= '0;
    else       pending_reg <= pending_next;
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue controller: scoreboard/structural/port stall logic, write-back
// reservation table and div/sqrt FSM. Define FPU_SQRT_EN to enable fsqrt.
module fp_issue_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES  = 12,
  parameter int SQRT_CYCLES = 14,
  parameter int PIPE_LAT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       FpValidD,
  input  logic [2:0] FpOpD,
  input  logic       FpRegWriteD,
  input  logic [4:0] RdD,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs3D,
  input  logic       UsesRs3D,
  input  logic       FlushD,
  output logic       StallD,
  output logic       IssueE,
  output logic       DivStart,
  output logic       SqrtStart,
  output logic       IterBusy,
  output logic       IllegalD,
  output logic       WbValidW,
  output logic [4:0] WbRdW,
  output logic [1:0] ResultSelW
);

`ifdef FPU_SQRT_EN
  localparam bit SQRT_EN = 1'b1;
`else
  localparam bit SQRT_EN = 1'b0;
`endif
  localparam int LMAX = calc_lmax(DIV_CYCLES, SQRT_CYCLES, PIPE_LAT, SQRT_EN);
  // Wide enough for every latency even when LMAX excludes sqrt.
  localparam int LW   = $clog2(calc_lmax(DIV_CYCLES, SQRT_CYCLES, PIPE_LAT, 1'b1) + 1);

  logic [LW-1:0] lat;
  logic [1:0]    sel;
  logic          is_div;
  logic          is_sqrt;
  logic          hazard;
  logic          structural;
  logic          port_busy;
  logic          active;
  logic          reserve;
  logic          iter_start;
  logic [LMAX-1:0] port_hit;
  rsv_entry_t    new_entry;
  rsv_entry_t [LMAX-1:0] rsv_reg;
  rsv_entry_t [LMAX-1:0] rsv_next;
  iter_state_t   state_reg;
  iter_state_t   state_next;
  logic [LW-1:0] cnt_reg;
  logic [LW-1:0] cnt_next;

  always_comb begin
    lat     = LW'(1);
    sel     = SEL_SIMPLE;
    is_div  = 1'b0;
    is_sqrt = 1'b0;
    case (FpOpD)
      OP_ADD, OP_MUL: begin
        lat = LW'(PIPE_LAT);
        sel = SEL_PIPE;
      end
      OP_DIV: begin
        lat    = LW'(DIV_CYCLES);
        sel    = SEL_ITER;
        is_div = 1'b1;
      end
      OP_SQRT: begin
        lat     = LW'(SQRT_CYCLES);
        sel     = SEL_ITER;
        is_sqrt = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FPU_SQRT_EN
  assign IllegalD  = 1'b0;
  assign SqrtStart = IssueE & is_sqrt;
`else
  assign IllegalD  = FpValidD & is_sqrt;
  assign SqrtStart = 1'b0;
`endif

  fp_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (reserve),
    .set_idx (RdD),
    .clr_en  (rsv_reg[0].valid),
    .clr_idx (rsv_reg[0].rd),
    .rs1     (Rs1D),
    .rs2     (Rs2D),
    .rs3     (Rs3D),
    .rd      (RdD),
    .use_rs3 (UsesRs3D),
    .use_rd  (FpRegWriteD),
    .hazard  (hazard)
  );

  assign structural = (is_div | is_sqrt) & IterBusy;
  assign port_busy  = FpRegWriteD & (|port_hit);
  assign active     = FpValidD & ~FlushD & ~IllegalD;
  assign StallD     = active & (hazard | structural | port_busy);
  assign IssueE     = active & ~StallD;
  assign DivStart   = IssueE & is_div;
  assign iter_start = DivStart | SqrtStart;
  assign reserve    = IssueE & FpRegWriteD;
  assign new_entry  = {1'b1, RdD, sel};

  // Entry i describes the write-back slot i cycles from now; entry 0 is this cycle's.
  genvar gi;
  generate
    for (gi = 0; gi < LMAX; gi++) begin : g_rsv
      rsv_entry_t shifted;
      if (gi == LMAX - 1) begin : g_top
        assign shifted = '0;
      end else begin : g_mid
        assign shifted = rsv_reg[gi+1];
      end
      assign port_hit[gi] = rsv_reg[gi].valid && (lat == LW'(gi));
      assign rsv_next[gi] = (reserve && (lat == LW'(gi + 1))) ? new_entry : shifted;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) rsv_reg <= '0;
    else       rsv_reg <= rsv_next;
  end

  assign WbValidW   = rsv_reg[0].valid;
  assign WbRdW      = rsv_reg[0].rd;
  assign ResultSelW = rsv_reg[0].sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Busy for L-1 cycles, so a follow-on op can start in the write-back cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (iter_start) begin
          state_next = RUN;
          cnt_next   = lat - LW'(1);
        end
      end
      RUN: begin
        cnt_next = cnt_reg - LW'(1);
        if (cnt_reg == LW'(1)) state_next = IDLE;
      end
    endcase
  end

  assign IterBusy = (state_reg == RUN);

endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Issue controller for the RV32F floating-point datapath. It sits between Decode and the FP execute units. For every FP instruction in Decode it:
- decides whether the instruction may issue, using a per-register scoreboard, the busy state of the shared iterative div/sqrt unit and a single-writeback-port reservation table;
- starts the iterative unit when required;
- tells Writeback which FP register is written each cycle, and from which source.

## Interface
- `DIV_CYCLES`, 12: issue-to-writeback latency of fdiv.
- `SQRT_CYCLES`, 14: issue-to-writeback latency of fsqrt.
- `PIPE_LAT`, 3: latency of pipelined add/sub/mul/fma.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `FpValidD` in 1: Decode holds a valid FP instruction.
- `FpOpD` in 3: op class. 000 add/sub/fma, 001 mul, 010 div, 011 sqrt, 100 simple (sign-inject, move, compare, convert). 101–111 are treated as 100.
- `FpRegWriteD` in 1: the instruction writes an f-register.
- `RdD`, `Rs1D`, `Rs2D`, `Rs3D` in 5 each: destination and source register indices.
- `UsesRs3D` in 1: `Rs3D` is a real operand.
- `FlushD` in 1: kill the Decode instruction this cycle.
- `StallD` out 1: hold Fetch/Decode.
- `IssueE` out 1: instruction enters Execute this cycle.
- `DivStart`, `SqrtStart` out 1: one-cycle start pulse to the iterative unit.
- `IterBusy` out 1: iterative unit occupied.
- `IllegalD` out 1: unsupported op in Decode.
- `WbValidW` out 1: an FP write-back occurs this cycle.
- `WbRdW` out 5: destination of that write-back.
- `ResultSelW` out 2: result source. 00 pipe, 01 simple, 10 iterative.

## Operation
- **Op latency L:** simple = 1; add/sub/mul = `PIPE_LAT`; div = `DIV_CYCLES`; sqrt = `SQRT_CYCLES`. LMAX = max of all L.
- **Scoreboard:** 32 pending bits, one per f-register.
  - A bit is set on `IssueE` when `FpRegWriteD` is high.
  - A bit is cleared on the cycle its `WbValidW` fires.
  - Set and clear of the same index in the same cycle resolves to set.
- **Stall conditions:** `StallD` = `FpValidD` & !`FlushD` & (hazard | structural | port). Each term:
  - hazard: pending[Rs1D] or pending[Rs2D], or pending[Rs3D] when `UsesRs3D`, or (pending[RdD] when `FpRegWriteD`) — this last term is the WAW check.
  - structural: op is div/sqrt and `IterBusy` is high.
  - port: the write-back slot at cycle t+L is already reserved.
- **Issue:** `IssueE` = `FpValidD` & !`FlushD` & !`StallD` & !`IllegalD`.
- **Reservation table:** LMAX entries; each entry holds {valid, rd[4:0], sel[1:0]}.
  - The table shifts one entry per cycle.
  - Issue writes entry L.
  - Entry 0 drives `WbValidW`, `WbRdW` and `ResultSelW`.
  - Instructions with `FpRegWriteD`=0 (e.g. feq writing an x-register) reserve nothing and never stall on the port.
- **Iterative FSM:** states `IDLE` → `RUN` → `IDLE`.
  - Issuing a div/sqrt pulses `DivStart`/`SqrtStart`, loads the down-counter with L−1 and enters `RUN`.
  - `IterBusy` is high for cycles t+1 … t+L−1; the FSM returns to `IDLE` when the counter reaches 0.
  - A new div/sqrt can therefore issue in the same cycle as the previous one's write-back.
- **Flush:** `FlushD` suppresses issue, stall and start pulses. Scoreboard, table and FSM are unchanged, so in-flight operations complete.
- **Reset:** clears the scoreboard and table and forces the FSM to `IDLE`. All outputs are 0 from the first cycle after the reset edge. Any operation in flight at reset is lost with no write-back.

## Timing
- Stall, illegal and issue decisions are combinational from D-stage inputs and registered state; there are no combinational paths from W outputs back to inputs.
- Start pulses are combinational and coincide with `IssueE`.
- Write-back occurs exactly L cycles after the issue cycle. `WbValidW` is a registered output.
- Back-to-back issue of independent pipe ops: one per cycle.

## Configuration
- **`FPU_SQRT_EN` defined:** op 011 follows the rules above.
- **`FPU_SQRT_EN` undefined:**
  - op 011 with `FpValidD` drives `IllegalD`=1;
  - `StallD`=0, `IssueE`=0, no reservation and no scoreboard change;
  - `SqrtStart` is tied 0;
  - LMAX excludes `SQRT_CYCLES`.
- `IllegalD` is 0 in all other cases.

## Structure
- Package `fp_ctrl_pkg` holds:
  - op-class localparams;
  - `ResultSelW` encodings;
  - the FSM state enum;
  - a constant function computing LMAX.
- Sub-module `fp_scoreboard` holds the 32-bit pending vector, set/clear logic and the 4-port (Rs1/Rs2/Rs3/Rd) hazard lookup.
- Reservation table and FSM stay in the top module.

## Test plan
- **Dependent pipe ops:** reset, then fadd f1 then fadd f2←f1 back-to-back. Expect the second stalls 2 cycles and issues 3 cycles after the first; `WbRdW`=1 then 2, `ResultSelW`=00.
- **Div then divs:** fdiv f3 at cycle 0, independent fdiv at cycle 1. Expect stall until cycle 12, second `DivStart` at cycle 12, write-backs at 12 and 24.
- **Port conflict:** fdiv at cycle 0 (slot 12), fadd at cycle 9 (slot 12 taken). Expect the fadd stalls at cycle 9 and issues at cycle 10 with write-back at cycle 13.
- **WAW:** fmul f5 then fmv f5. Expect the fmv stalls until the fmul write-back cycle, then issues.
- **Flush and reset:** a stalled instruction with `FlushD` gives `StallD`=0, `IssueE`=0. Asserting `reset` at cycle 5 of an fdiv gives all outputs 0 and no write-back at cycle 12.
- **Sqrt macro off:** with `FPU_SQRT_EN` undefined, fsqrt gives `IllegalD`=1, no issue, no stall.
